// File: rtl/if_stage_pkg.sv
// Shared constants for the RV32I instruction-fetch stage.
package if_stage_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef logic [0:0] if_state_t;
  localparam if_state_t IF_RUN  = 1'b0;
  localparam if_state_t IF_HELD = 1'b1;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: control from stall/redirect logic, imem port and IF/ID outputs.
interface if_stage_if #(
  parameter int PC_WIDTH = 10
);
  logic                  stall;
  logic                  redirect;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic                  imem_en;
  logic [PC_WIDTH-3:0]   imem_addr;
  logic [31:0]           imem_data;
  logic [PC_WIDTH-1:0]   id_pc;
  logic [31:0]           id_inst;
  logic                  id_valid;

  modport master (
    input  stall, redirect, redirect_pc, imem_data,
    output imem_en, imem_addr, id_pc, id_inst, id_valid
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_data,
    input  imem_en, imem_addr, id_pc, id_inst, id_valid
  );
endinterface

// File: rtl/if_hold_buf.sv
// One-entry {pc, inst, valid} buffer that parks an in-flight instruction during a stall.
module if_hold_buf
  import if_stage_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_clr,
  input  logic [AW-1:0] i_pc,
  input  logic [31:0]   i_inst,
  output logic          o_valid,
  output logic [AW-1:0] o_pc,
  output logic [31:0]   o_inst
);

  logic          r_valid;
  logic [AW-1:0] r_pc;
  logic [31:0]   r_inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= NOP_INST;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, sync imem driver, IF/ID register with stall hold and redirect.
// PCs are tracked as word addresses internally; the byte-offset bits are always zero.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                  PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic      clk,
  input  logic      rst,
  if_stage_if.master bus
);

  localparam int AW = PC_WIDTH - 2;

  logic [AW-1:0] r_fetch_wa;
  logic          r_infl_vld;
  logic [AW-1:0] r_infl_wa;
  if_state_t     r_state;
  logic          r_id_vld;
  logic [AW-1:0] r_id_wa;
  logic [31:0]   r_id_inst;

  logic [AW-1:0] w_tgt_wa;
  logic          w_unused_lsb;
  logic          w_normal;
  logic          w_hold_load;
  logic          w_hold_clr;
  logic          w_hold_vld;
  logic [AW-1:0] w_hold_wa;
  logic [31:0]   w_hold_inst;
  logic          w_use_hold;

  assign w_tgt_wa     = bus.redirect_pc[PC_WIDTH-1:2];
  assign w_unused_lsb = ^bus.redirect_pc[1:0];

  assign w_normal    = !rst && !bus.redirect && !bus.stall;
  assign w_use_hold  = (r_state == IF_HELD) && w_hold_vld;
  assign w_hold_load = !rst && !bus.redirect && bus.stall && r_infl_vld;
  assign w_hold_clr  = bus.redirect || (w_normal && r_state == IF_HELD);

  always_comb begin
    bus.imem_en   = 1'b0;
    bus.imem_addr = r_fetch_wa;
    if (!rst) begin
      if (bus.redirect) begin
        bus.imem_en   = 1'b1;
        bus.imem_addr = w_tgt_wa;
      end else if (!bus.stall) begin
        bus.imem_en = 1'b1;
      end
    end
  end

  if_hold_buf #(.AW(AW)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_hold_load),
    .i_clr   (w_hold_clr),
    .i_pc    (r_infl_wa),
    .i_inst  (bus.imem_data),
    .o_valid (w_hold_vld),
    .o_pc    (w_hold_wa),
    .o_inst  (w_hold_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_wa <= RESET_PC[PC_WIDTH-1:2];
      r_infl_vld <= 1'b0;
      r_infl_wa  <= '0;
      r_state    <= IF_RUN;
      r_id_vld   <= 1'b0;
      r_id_wa    <= '0;
      r_id_inst  <= NOP_INST;
    end else if (bus.redirect) begin
      // Data arriving this cycle belongs to the old path and is dropped.
      r_infl_wa  <= w_tgt_wa;
      r_infl_vld <= 1'b1;
      r_fetch_wa <= w_tgt_wa + AW'(1);
      r_state    <= IF_RUN;
      r_id_vld   <= 1'b0;
      r_id_wa    <= '0;
      r_id_inst  <= NOP_INST;
    end else if (bus.stall) begin
      if (r_infl_vld) begin
        r_infl_vld <= 1'b0;
        r_state    <= IF_HELD;
      end
    end else begin
      r_infl_wa  <= r_fetch_wa;
      r_infl_vld <= 1'b1;
      r_fetch_wa <= r_fetch_wa + AW'(1);
      if (w_use_hold) begin
        r_state   <= IF_RUN;
        r_id_vld  <= 1'b1;
        r_id_wa   <= w_hold_wa;
        r_id_inst <= w_hold_inst;
      end else if (r_infl_vld) begin
        r_state   <= IF_RUN;
        r_id_vld  <= 1'b1;
        r_id_wa   <= r_infl_wa;
        r_id_inst <= bus.imem_data;
      end else begin
        r_state   <= IF_RUN;
        r_id_vld  <= 1'b0;
        r_id_wa   <= '0;
        r_id_inst <= NOP_INST;
      end
    end
  end

  assign bus.id_pc    = {r_id_wa, 2'b00};
  assign bus.id_inst  = r_id_inst;
  assign bus.id_valid = r_id_vld;

endmodule
